usb_rx_packet_buffer: RTL

USB_RX_PACKET_BUFFER -- requirements
Module: usb_rx_packet_buffer

---
 rtl/usb_rx_packet_buffer_pkg.sv | 34 +++
 rtl/usb_crc16.sv | 30 +++
 rtl/usb_rx_packet_buffer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/usb_rx_packet_buffer_pkg.sv
// Shared constants for the USB receive packet buffer: PIDs, CRC16 parameters, FSM encoding.
// Latency: n/a (constants and a pure combinational helper).
// Backpressure: n/a.
package usb_rx_packet_buffer_pkg;

    localparam int BUF_ADDR_W = 10;
    localparam int BUF_DEPTH  = 1 << BUF_ADDR_W;

    localparam logic [7:0] PID_SETUP = 8'h2D;
    localparam logic [7:0] PID_OUT   = 8'hE1;
    localparam logic [7:0] PID_DATA0 = 8'hC3;
    localparam logic [7:0] PID_DATA1 = 8'h4B;

    // Reflected (LSB-first) USB CRC16; a clean packet including its CRC bytes leaves CRC16_RESID.
    localparam logic [15:0] CRC16_POLY  = 16'hA001;
    localparam logic [15:0] CRC16_INIT  = 16'hFFFF;
    localparam logic [15:0] CRC16_RESID = 16'hB001;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RECV = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;
    localparam logic [1:0] ST_FULL = 2'd3;

    // Advance the CRC by one byte, least significant bit first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] d);
        logic [15:0] c;
        c = crc ^ {8'h00, d};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC16_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/usb_crc16.sv
// Byte-wide USB CRC16 register with synchronous clear and enable.
// Latency: updated value visible one cycle after the enabled byte.
// Backpressure: none; consumes a byte on every cycle en is high.
module usb_crc16
    import usb_rx_packet_buffer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [15:0] crc
);

    // Clear and enable together restart the CRC with this byte as the first one.
    logic [15:0] base;
    assign base = clr ? CRC16_INIT : crc;

    // CRC state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc <= CRC16_INIT;
        end else if (en) begin
            crc <= crc16_byte(base, data);
        end else if (clr) begin
            crc <= CRC16_INIT;
        end
    end

endmodule

// File: rtl/usb_rx_packet_buffer.sv
// Single-packet USB OUT/SETUP receive buffer with CRC16 check and commit/release handshake.
// Latency: pkt_valid_o one cycle after data_i_end; rd_data_o one cycle after rd_addr_i.
// Backpressure: none on the byte stream; packets arriving while a packet is held are dropped (drop_o if armed).
module usb_rx_packet_buffer
    import usb_rx_packet_buffer_pkg::*;
(
    input  logic        USB_CLKIN,
    input  logic        RST,
    input  logic [6:0]  dev_addr_i,
    input  logic [23:0] token_i,
    input  logic        token_i_strb,
    input  logic [7:0]  pid_i,
    input  logic [7:0]  data_i,
    input  logic        data_i_strb,
    input  logic        data_i_end,
    input  logic        data_i_fail,
    input  logic [9:0]  rd_addr_i,
    output logic [7:0]  rd_data_o,
    input  logic        pkt_release_i,
    output logic        pkt_valid_o,
    output logic [10:0] pkt_len_o,
    output logic [7:0]  pkt_pid_o,
    output logic [3:0]  pkt_endp_o,
    output logic        pkt_setup_o,
    output logic        crc_err_o,
    output logic        ovf_err_o,
    output logic        drop_o
);

    logic [1:0]            state;
    logic                  armed;
    logic [3:0]            tok_endp;
    logic                  tok_setup;
    logic                  cur_armed;
    logic [3:0]            cur_endp;
    logic                  cur_setup;
    logic [7:0]            cur_pid;
    logic [BUF_ADDR_W:0]   count;
    logic [15:0]           crc;
    logic [7:0]            mem [0:BUF_DEPTH-1];

    logic                  first_byte;
    logic                  pid_ok;
    logic                  start_recv;
    logic                  wr_en;
    logic [BUF_ADDR_W-1:0] wr_addr;
    logic                  tok_match;

    // The token CRC5 has already been checked upstream.
    logic unused_tok_crc5;
    assign unused_tok_crc5 = ^token_i[23:19];

    assign tok_match  = ((token_i[7:0] == PID_SETUP) || (token_i[7:0] == PID_OUT))
                        && (token_i[14:8] == dev_addr_i);
    assign first_byte = data_i_strb && ((state == ST_IDLE) || (state == ST_FULL));
    assign pid_ok     = (pid_i == PID_DATA0) || (pid_i == PID_DATA1);
    assign start_recv = data_i_strb && (state == ST_IDLE) && armed && pid_ok;
    // count saturates at BUF_DEPTH, so the top bit set means the buffer is exhausted.
    assign wr_en      = start_recv || (data_i_strb && (state == ST_RECV) && !count[BUF_ADDR_W]);
    assign wr_addr    = start_recv ? '0 : count[BUF_ADDR_W-1:0];

    usb_crc16 u_crc (
        .clk  (USB_CLKIN),
        .rst  (RST),
        .clr  (start_recv),
        .en   (wr_en),
        .data (data_i),
        .crc  (crc)
    );

    // Token tracking: a data packet consumes the armed flag; a token seen mid-packet arms the next one.
    always_ff @(posedge USB_CLKIN or posedge RST) begin
        if (RST) begin
            armed     <= 1'b0;
            tok_endp  <= '0;
            tok_setup <= 1'b0;
            cur_armed <= 1'b0;
            cur_endp  <= '0;
            cur_setup <= 1'b0;
            cur_pid   <= '0;
        end else begin
            if (first_byte) begin
                cur_armed <= armed;
                cur_endp  <= tok_endp;
                cur_setup <= tok_setup;
                cur_pid   <= pid_i;
            end
            if (token_i_strb) begin
                armed     <= tok_match;
                tok_endp  <= token_i[18:15];
                tok_setup <= (token_i[7:0] == PID_SETUP);
            end else if (first_byte) begin
                armed     <= 1'b0;
            end
        end
    end

    // Packet RAM write port; contents are deliberately not reset.
    always_ff @(posedge USB_CLKIN) begin
        if (wr_en) begin
            mem[wr_addr] <= data_i;
        end
    end

    // Registered read port.
    always_ff @(posedge USB_CLKIN or posedge RST) begin
        if (RST) begin
            rd_data_o <= '0;
        end else begin
            rd_data_o <= mem[rd_addr_i];
        end
    end

    // Receive FSM, commit of packet descriptors and one-cycle status pulses.
    always_ff @(posedge USB_CLKIN or posedge RST) begin
        if (RST) begin
            state       <= ST_IDLE;
            count       <= '0;
            pkt_valid_o <= 1'b0;
            pkt_len_o   <= '0;
            pkt_pid_o   <= '0;
            pkt_endp_o  <= '0;
            pkt_setup_o <= 1'b0;
            crc_err_o   <= 1'b0;
            ovf_err_o   <= 1'b0;
            drop_o      <= 1'b0;
        end else begin
            crc_err_o <= 1'b0;
            ovf_err_o <= 1'b0;
            drop_o    <= 1'b0;
            if (pkt_release_i && ((state == ST_FULL) || (state == ST_DROP))) begin
                pkt_valid_o <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (data_i_strb) begin
                        if (armed && pid_ok) begin
                            state <= ST_RECV;
                            count <= 11'd1;
                        end else begin
                            state <= ST_DROP;
                        end
                    end
                end
                ST_RECV: begin
                    if (data_i_fail) begin
                        state <= ST_IDLE;
                    end else if (data_i_end) begin
                        if ((count >= 11'd2) && (crc == CRC16_RESID)) begin
                            state       <= ST_FULL;
                            pkt_valid_o <= 1'b1;
                            pkt_len_o   <= count - 11'd2;
                            pkt_pid_o   <= cur_pid;
                            pkt_endp_o  <= cur_endp;
                            pkt_setup_o <= cur_setup;
                        end else begin
                            crc_err_o <= 1'b1;
                            state     <= ST_IDLE;
                        end
                    end else if (data_i_strb) begin
                        if (count[BUF_ADDR_W]) begin
                            ovf_err_o <= 1'b1;
                            state     <= ST_DROP;
                        end else begin
                            count <= count + 11'd1;
                        end
                    end
                end
                ST_DROP: begin
                    if (data_i_end || data_i_fail) begin
                        drop_o <= cur_armed;
                        state  <= (pkt_valid_o && !pkt_release_i) ? ST_FULL : ST_IDLE;
                    end
                end
                default: begin
                    if (data_i_strb) begin
                        state <= ST_DROP;
                    end else if (pkt_release_i) begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
